demux16_collector: RTL and testbench

- Sequential 1-to-16 demultiplexer: the write-side counterpart of the 16:1 bit-select mux.
- Accepts a stream of single bits, each tagged with a 4-bit index S. Steers each bit into position S of a 16-bit assembly register.
- Presents the completed word under a valid/ready handshake.
- Used to build shift/alignment and mantissa words bit-by-bit for the floating-point datapath.

---
 rtl/demux16_collector.sv | 58 +++++
 tb/tb_demux16_collector.sv | 104 ++++++++++
 2 files changed

// File: rtl/demux16_collector.sv
// demux16_collector: steers a stream of (S, I) bits into a 16-lane word and offers it under valid/ready.
// Ports:
//   clk, rst                      clock and synchronous active-high reset
//   in_valid, in_ready, S, I      bit input; I is written to lane S
//   in_last                       closes the frame after this write
//   out_valid, out_ready          completed-word handshake
//   op, op_mask, err              word, lanes written this frame, and a repeated-lane flag
module demux16_collector #(
  parameter int SEL_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SEL_W-1:0]      S,
  input  logic                  I,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2**SEL_W-1:0]   op,
  output logic [2**SEL_W-1:0]   op_mask,
  output logic                  err
);
  localparam int WIDTH = 2**SEL_W;
  typedef enum logic {COLLECT, HOLD} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] onehot;
  logic wr, rel;
  assign onehot    = {{(WIDTH-1){1'b0}}, 1'b1} << S;
  assign in_ready  = (state == COLLECT) & ~rst;
  assign out_valid = (state == HOLD);
  assign wr        = in_valid & in_ready;
  assign rel       = (state == HOLD) & out_ready;
  always_comb begin
    state_nx = state;
    if (wr) state_nx = (in_last | (&(op_mask | onehot))) ? HOLD : COLLECT;
    else if (rel) state_nx = COLLECT;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= COLLECT;
      op      <= '0;
      op_mask <= '0;
      err     <= 1'b0;
    end else begin
      state <= state_nx;
      if (wr) begin
        op[S]      <= I;
        op_mask[S] <= 1'b1;
        if (op_mask[S]) err <= 1'b1;
      end else if (rel) begin
        op      <= '0;
        op_mask <= '0;
        err     <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_demux16_collector.sv
// tb_demux16_collector: directed plus random check of demux16_collector against a frame-level model.
module tb_demux16_collector;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [3:0] S = '0;
  logic I = 1'b0;
  logic in_last = 1'b0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [15:0] op, op_mask;
  logic err;
  int total = 0;
  int bad = 0;
  logic [15:0] m_op = '0;
  logic [15:0] m_mask = '0;
  logic m_err = 1'b0;
  logic m_hold = 1'b0;
  logic [15:0] pat = 16'hA5C3;
  always #5 clk = ~clk;
  demux16_collector dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .S(S), .I(I), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .op(op), .op_mask(op_mask), .err(err)
  );
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic check_all();
    chk("out_valid", {15'd0, out_valid}, {15'd0, m_hold});
    chk("in_ready", {15'd0, in_ready}, {15'd0, ~m_hold & ~rst});
    chk("op", op, m_op);
    chk("op_mask", op_mask, m_mask);
    chk("err", {15'd0, err}, {15'd0, m_err});
  endtask
  // One clock: apply inputs, advance the frame model, then compare just after the edge.
  task automatic cyc(input logic v, input int s, input logic i, input logic last,
                     input logic ordy, input logic r);
    rst = r; in_valid = v; S = 4'(s); I = i; in_last = last; out_ready = ordy;
    @(posedge clk);
    if (r) begin
      m_op = '0; m_mask = '0; m_err = 1'b0; m_hold = 1'b0;
    end else if (!m_hold && v) begin
      if (m_mask[s]) m_err = 1'b1;
      m_op[s] = i;
      m_mask[s] = 1'b1;
      if (last || m_mask == 16'hFFFF) m_hold = 1'b1;
    end else if (m_hold && ordy) begin
      m_op = '0; m_mask = '0; m_err = 1'b0; m_hold = 1'b0;
    end
    #1;
    check_all();
  endtask
  initial begin
    cyc(0, 0, 0, 0, 0, 1);
    chk("rst_op", op, 16'h0000);
    chk("rst_in_ready", {15'd0, in_ready}, 16'd0);
    cyc(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 16; k++) cyc(1, k, pat[k], 0, 0, 0);
    chk("full_op", op, 16'hA5C3);
    chk("full_mask", op_mask, 16'hFFFF);
    chk("full_valid", {15'd0, out_valid}, 16'd1);
    for (int k = 0; k < 5; k++) cyc(0, 0, 0, 0, 0, 0);
    chk("hold_op", op, 16'hA5C3);
    chk("hold_in_ready", {15'd0, in_ready}, 16'd0);
    cyc(0, 0, 0, 0, 1, 0);
    chk("rel_op", op, 16'h0000);
    chk("rel_in_ready", {15'd0, in_ready}, 16'd1);
    cyc(1, 3, 1, 0, 0, 0);
    cyc(1, 9, 1, 1, 0, 0);
    chk("last_op", op, 16'h0208);
    chk("last_mask", op_mask, 16'h0208);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(1, 5, 1, 0, 0, 0);
    cyc(1, 5, 0, 0, 0, 0);
    cyc(1, 0, 1, 1, 0, 0);
    chk("dup_op", op, 16'h0001);
    chk("dup_mask", op_mask, 16'h0021);
    chk("dup_err", {15'd0, err}, 16'd1);
    for (int k = 0; k < 3; k++) cyc(1, 7, 1, 0, 0, 0);
    chk("hold_ignore_op", op, 16'h0001);
    cyc(0, 0, 0, 0, 1, 0);
    chk("next_err", {15'd0, err}, 16'd0);
    for (int k = 0; k < 8; k++) cyc(1, k, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    chk("midrst_mask", op_mask, 16'h0000);
    cyc(1, 15, 1, 1, 0, 0);
    chk("lane15_op", op, 16'h8000);
    cyc(0, 0, 0, 0, 1, 1);
    chk("holdrst_valid", {15'd0, out_valid}, 16'd0);
    chk("holdrst_op", op, 16'h0000);
    for (int k = 0; k < 600; k++)
      cyc(($urandom_range(0, 3) != 0), int'($urandom_range(0, 15)), 1'($urandom),
          ($urandom_range(0, 9) == 0), ($urandom_range(0, 2) == 0),
          ($urandom_range(0, 79) == 0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
